bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and transfer sequencer for the shared processor interconnect bus. It accepts per-processor requests with destinations and grants the bus to one requester at a time. It holds the bus for a fixed transfer length, then signals completion to the destination (a processor or memory). It sits between the processor request ports and the bus datapath, and owns all bus occupancy decisions.

## Interface
- NUM_PROC, 4, number of requesting processors (≥2)
- XFER_CYCLES, 3, bus occupancy cycles per transfer (≥1)
- DW (derived), $clog2(NUM_PROC)+1, destination field width; value NUM_PROC = memory
- Reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- request  in  NUM_PROC  per-processor request level; held until granted
- request_dest  in  NUM_PROC×DW  destination per requester: 0..NUM_PROC-1 processor, NUM_PROC memory, >NUM_PROC invalid
- grant  out  NUM_PROC  one-hot, one-cycle grant pulse
- busy  out  1  bus owned (state ≠ IDLE)
- cur_src  out  $clog2(NUM_PROC)  current owner index; valid while busy
- processed_request  out  1  one-cycle pulse at successful transfer completion
- request_avail  out  NUM_PROC  one-hot pulse to destination processor at completion
- mem_avail  out  1  completion pulse when destination is memory
- dest_err  out  1  one-cycle pulse when granted request has invalid destination

## Operation
- States: IDLE, GRANT, XFER, DONE.
- IDLE: if any request bit is high at the edge, select the winner round-robin and go to GRANT, latching src and dest. Otherwise stay in IDLE.
- Round-robin: search starts at last_grant+1 mod NUM_PROC. last_grant resets to NUM_PROC-1, so processor 0 has first priority. last_grant updates on every grant.
- GRANT (1 cycle): grant[src]=1.
  - Valid dest: go to XFER with counter = XFER_CYCLES-1.
  - Invalid dest (>NUM_PROC): dest_err=1, go to IDLE. No transfer, no completion pulses.
- XFER: counter decrements each cycle. At counter==0, go to DONE.
- DONE (1 cycle): processed_request=1. If dest<NUM_PROC, request_avail[dest]=1; if dest==NUM_PROC, mem_avail=1.
  - DONE also arbitrates: if any request is pending, go directly to GRANT; else go to IDLE.
- Self-destination (dest==src) is legal and delivers normally.
- Requesters must drop request in the cycle after seeing grant. The arbiter samples request only in IDLE and DONE.
- request_dest is sampled only at the arbitration edge. Later changes are ignored.

## Timing
- Reset values: state IDLE, grant 0, busy 0, cur_src 0, processed_request 0, request_avail 0, mem_avail 0, dest_err 0, last_grant NUM_PROC-1, counter 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from request to outputs.
- Request seen at edge E0 in IDLE:
  - grant in cycle after E0;
  - XFER occupies the next XFER_CYCLES cycles;
  - completion pulses occur XFER_CYCLES+1 cycles after the grant cycle (default: grant cycle 1, completion cycle 5).
- Back-to-back grant spacing: XFER_CYCLES+2 cycles (default 5).
- Invalid-dest grant to next grant: minimum 2 cycles (GRANT→IDLE→GRANT).
- Simultaneous requests: exactly one grant per arbitration. Losers wait with no loss.
- rst asserted in any state: the immediate return to reset values aborts the transfer. No completion pulse for the aborted transfer.
- Counter width $clog2(XFER_CYCLES); XFER_CYCLES=1 means a single XFER cycle.

## Test plan
- Reset, then request[0]=1, dest=4 (memory) → grant=0001 in cycle 1; busy cycles 1–5; mem_avail and processed_request in cycle 5; request_avail stays 0.
- All four request at once, dests 1,2,3,0 → grants 0,1,2,3 in cycles 1,6,11,16; request_avail pulses 0010,0100,1000,0001 in cycles 5,10,15,20.
- After processor 1 is granted, processors 0 and 3 request → 3 is granted before 0.
- request[2] with dest=6 → grant=0100 and dest_err in the same cycle. No processed_request. A pending request[0] is granted 2 cycles later.
- rst pulsed in the second XFER cycle → all outputs 0 immediately, no completion pulse. After release, processor 0 wins next.
- request[1] with dest=1 → request_avail=0010 and processed_request in cycle 5.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request/grant/completion bundle between processor ports and the bus arbiter.
// The arbiter uses the slave modport; the requesting side uses master.
interface bus_arbiter_if #(
  parameter int unsigned NUM_PROC = 4
);
  localparam int unsigned SW = $clog2(NUM_PROC);
  localparam int unsigned DW = SW + 1;

  logic [NUM_PROC-1:0]          request;
  logic [NUM_PROC-1:0][DW-1:0]  request_dest;
  logic [NUM_PROC-1:0]          grant;
  logic                         busy;
  logic [SW-1:0]                cur_src;
  logic                         processed_request;
  logic [NUM_PROC-1:0]          request_avail;
  logic                         mem_avail;
  logic                         dest_err;

  modport master (
    output request, request_dest,
    input  grant, busy, cur_src, processed_request, request_avail, mem_avail, dest_err
  );

  modport slave (
    input  request, request_dest,
    output grant, busy, cur_src, processed_request, request_avail, mem_avail, dest_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one requester, holds the bus for XFER_CYCLES,
// then pulses completion toward the destination processor or memory.
module bus_arbiter #(
  parameter int unsigned NUM_PROC    = 4,
  parameter int unsigned XFER_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(NUM_PROC);
  localparam int unsigned DW = SW + 1;
  localparam int unsigned CW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
  localparam logic [DW-1:0] MemDest = DW'(NUM_PROC);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [SW-1:0]       r_src;
  logic [DW-1:0]       r_dest;
  logic [SW-1:0]       r_last_grant;
  logic [CW-1:0]       r_cnt;

  logic                w_found;
  logic [SW-1:0]       w_winner;
  logic [SW-1:0]       w_idx;
  logic                w_dest_ok;
  logic                w_arb;
  logic [NUM_PROC-1:0] w_grant;
  logic [NUM_PROC-1:0] w_avail;
  logic                w_mem;
  logic                w_pr;
  logic                w_err;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 1; i <= NUM_PROC; i++) begin
      w_idx = SW'((r_last_grant + i) % NUM_PROC);
      if (!w_found && bus.request[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_dest_ok = (r_dest <= MemDest);
  assign w_arb     = (r_state == StIdle) || (r_state == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_found) w_state_next = StGrant;
      StGrant: w_state_next = w_dest_ok ? StXfer : StIdle;
      StXfer:  if (r_cnt == '0) w_state_next = StDone;
      StDone:  w_state_next = w_found ? StGrant : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Owner and destination are captured only at the arbitration edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src        <= '0;
      r_dest       <= '0;
      r_last_grant <= SW'(NUM_PROC - 1);
      r_cnt        <= '0;
    end else begin
      if (w_arb && w_found) begin
        r_src        <= w_winner;
        r_dest       <= bus.request_dest[w_winner];
        r_last_grant <= w_winner;
      end
      if (r_state == StGrant) begin
        r_cnt <= CW'(XFER_CYCLES - 1);
      end else if (r_state == StXfer && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_avail = '0;
    w_mem   = 1'b0;
    w_pr    = 1'b0;
    w_err   = 1'b0;
    if (r_state == StGrant) begin
      w_grant[r_src] = 1'b1;
      w_err          = !w_dest_ok;
    end
    if (r_state == StDone) begin
      w_pr  = 1'b1;
      w_mem = (r_dest == MemDest);
      if (r_dest < MemDest) begin
        w_avail[r_dest[SW-1:0]] = 1'b1;
      end
    end
  end

  assign bus.grant             = w_grant;
  assign bus.busy              = (r_state != StIdle);
  assign bus.cur_src           = r_src;
  assign bus.processed_request = w_pr;
  assign bus.request_avail     = w_avail;
  assign bus.mem_avail         = w_mem;
  assign bus.dest_err          = w_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected grants are queued as requests are
// driven; completions are queued when their grant is seen.
module tb_bus_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned XC = 3;

  typedef struct {
    logic [3:0]  g;
    logic [2:0]  d;
    int unsigned src;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    int unsigned due;
    logic [3:0]  avail;
    logic        mem;
  } comp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  exp_t  exp_q[$];
  comp_t comp_q[$];

  bus_arbiter_if #(.NUM_PROC(NP)) bus ();

  bus_arbiter #(.NUM_PROC(NP), .XFER_CYCLES(XC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, {28'd0, bus.grant}, 0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    check({tag, "_cur_src"}, {30'd0, bus.cur_src}, 0);
    check({tag, "_pr"}, {31'd0, bus.processed_request}, 0);
    check({tag, "_avail"}, {28'd0, bus.request_avail}, 0);
    check({tag, "_mem"}, {31'd0, bus.mem_avail}, 0);
    check({tag, "_err"}, {31'd0, bus.dest_err}, 0);
  endtask

  task automatic monitor();
    exp_t  e;
    comp_t c;
    if (bus.grant != '0 || bus.dest_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", {27'd0, bus.dest_err, bus.grant}, 0);
      end else begin
        e = exp_q.pop_front();
        check("grant", {28'd0, bus.grant}, {28'd0, e.g});
        check("grant_cyc", cyc, e.cyc);
        check("dest_err", {31'd0, bus.dest_err}, {31'd0, (e.d > 3'd4)});
        check("cur_src", {30'd0, bus.cur_src}, e.src);
        if (e.d <= 3'd4) begin
          c.due   = cyc + XC + 1;
          c.avail = (e.d < 3'd4) ? (4'b0001 << e.d) : 4'b0000;
          c.mem   = (e.d == 3'd4);
          comp_q.push_back(c);
        end
      end
      bus.request = bus.request & ~bus.grant;
    end
    if (bus.processed_request || bus.mem_avail || bus.request_avail != '0) begin
      if (comp_q.size() == 0) begin
        check("unexpected_done",
              {26'd0, bus.processed_request, bus.mem_avail, bus.request_avail}, 0);
      end else begin
        c = comp_q.pop_front();
        check("done_cyc", cyc, c.due);
        check("processed", {31'd0, bus.processed_request}, 1);
        check("req_avail", {28'd0, bus.request_avail}, {28'd0, c.avail});
        check("mem_avail", {31'd0, bus.mem_avail}, {31'd0, c.mem});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic req(input int unsigned p, input logic [2:0] d, input int unsigned at);
    exp_t e;
    bus.request[p]      = 1'b1;
    bus.request_dest[p] = d;
    e.g   = 4'b0001 << p;
    e.d   = d;
    e.src = p;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || comp_q.size() != 0); k++) tick();
    check("drain_grants", exp_q.size(), 0);
    check("drain_dones", comp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    bus.request      = '0;
    bus.request_dest = '0;
    exp_q.delete();
    comp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.request      = '0;
    bus.request_dest = '0;
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single memory transfer; busy spans the grant cycle through completion.
    req(0, 3'd4, cyc + 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("busy", {31'd0, bus.busy}, {31'd0, (k <= 5)});
    end
    drain();

    // Four simultaneous requesters from a fresh reset.
    do_reset();
    req(0, 3'd1, cyc + 1);
    req(1, 3'd2, cyc + 6);
    req(2, 3'd3, cyc + 11);
    req(3, 3'd0, cyc + 16);
    drain();

    // Rotation: after 1 wins, 3 beats 0.
    req(1, 3'd2, cyc + 1);
    tick();
    req(3, 3'd4, cyc + 5);
    req(0, 3'd4, cyc + 10);
    drain();

    // Invalid destination, with 0 waiting behind it.
    req(2, 3'd6, cyc + 1);
    req(0, 3'd4, cyc + 3);
    drain();

    // Reset in the second transfer cycle aborts the transfer.
    req(1, 3'd0, cyc + 1);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_idle("abort");
    comp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    req(2, 3'd3, cyc + 6);
    req(0, 3'd0, cyc + 1);
    exp_q.reverse();
    drain();

    // Self-destination delivers normally.
    req(1, 3'd1, cyc + 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
